// File: rtl/if_stage_regs.sv
// Fetch-stage state: PC register, IF/ID pipeline register and saturating
// stall/flush/IM-wait debug counters, driven by the hazard unit's controls.
module if_stage_regs #(
   parameter logic [31:0] PC_RESET = 32'h0000_3000,
   parameter int unsigned CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             PCWr,
   input  logic             IFIDWr,
   input  logic             IFIDRst,
   input  logic [31:0]      NPC,
   input  logic [31:0]      IMInstr,
   input  logic             IMReady,
   output logic [31:0]      PC,
   output logic [31:0]      IFIDPC,
   output logic [31:0]      IFIDPCPLUS4,
   output logic [31:0]      IFIDIns,
   output logic             IFIDValid,
   output logic [CNT_W-1:0] StallCnt,
   output logic [CNT_W-1:0] FlushCnt,
   output logic [CNT_W-1:0] IMWaitCnt
);

   localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

   logic [31:0]      r_pc;
   logic [31:0]      r_ifid_pc;
   logic [31:0]      r_ifid_pc4;
   logic [31:0]      r_ifid_ins;
   logic             r_ifid_valid;
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;
   logic [CNT_W-1:0] r_imwait_cnt;

   logic w_pc_load;
   logic w_imwait;

   // A redirect discards the outstanding fetch, so it does not wait for IMReady.
   assign w_pc_load = PCWr & (IFIDRst | IMReady);
   assign w_imwait  = PCWr & ~IFIDRst & ~IMReady;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc <= PC_RESET & ALIGN_MASK;
      end else if (w_pc_load) begin
         r_pc <= NPC & ALIGN_MASK;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || IFIDRst) begin
         r_ifid_pc    <= '0;
         r_ifid_pc4   <= '0;
         r_ifid_ins   <= '0;
         r_ifid_valid <= 1'b0;
      end else if (IFIDWr) begin
         if (IMReady) begin
            r_ifid_pc    <= r_pc;
            r_ifid_pc4   <= r_pc + 32'd4;
            r_ifid_ins   <= IMInstr;
            r_ifid_valid <= 1'b1;
         end else begin
            r_ifid_pc    <= '0;
            r_ifid_pc4   <= '0;
            r_ifid_ins   <= '0;
            r_ifid_valid <= 1'b0;
         end
      end
   end

   // Performance counters stick at all-ones instead of wrapping.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_stall_cnt  <= '0;
         r_flush_cnt  <= '0;
         r_imwait_cnt <= '0;
      end else begin
         if (!PCWr && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         end
         if (IFIDRst && (r_flush_cnt != '1)) begin
            r_flush_cnt <= r_flush_cnt + CNT_W'(1);
         end
         if (w_imwait && (r_imwait_cnt != '1)) begin
            r_imwait_cnt <= r_imwait_cnt + CNT_W'(1);
         end
      end
   end

   assign PC          = r_pc;
   assign IFIDPC      = r_ifid_pc;
   assign IFIDPCPLUS4 = r_ifid_pc4;
   assign IFIDIns     = r_ifid_ins;
   assign IFIDValid   = r_ifid_valid;
   assign StallCnt    = r_stall_cnt;
   assign FlushCnt    = r_flush_cnt;
   assign IMWaitCnt   = r_imwait_cnt;

endmodule

// File: doc/if_stage_regs.md
Name: if_stage_regs

Overview:
- Front-end pipeline stage that consumes the stall/flush controls produced by the hazard unit: PCWr, IFIDWr and IFIDRst.
- Holds the PC register and the IF/ID pipeline register, and absorbs instruction-memory wait states.
- Sits between the NPC unit / instruction memory and the ID stage.
- Keeps saturating stall, flush and IM-wait counters for performance debug.

Parameters:
- PC_RESET, 32'h0000_3000, PC value loaded on reset.
- CNT_W, 16, width of each performance counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- PCWr  input  1  PC write enable from hazard unit (0 = stall).
- IFIDWr  input  1  IF/ID write enable from hazard unit (0 = hold).
- IFIDRst  input  1  IF/ID flush from hazard unit (redirect/bubble).
- NPC  input  32  next PC from NPC unit.
- IMInstr  input  32  instruction read at PC (combinational IM output).
- IMReady  input  1  IMInstr valid this cycle.
- PC  output  32  current fetch address.
- IFIDPC  output  32  PC of the instruction held in IF/ID.
- IFIDPCPLUS4  output  32  IFIDPC + 4.
- IFIDIns  output  32  instruction held in IF/ID (0 = nop).
- IFIDValid  output  1  IF/ID holds a real instruction.
- StallCnt  output  CNT_W  cycles with PCWr=0.
- FlushCnt  output  CNT_W  cycles with IFIDRst=1.
- IMWaitCnt  output  CNT_W  cycles lost to IMReady=0.

Behaviour:
- Reset: rst=1 at a clock edge sets:
  - PC=PC_RESET
  - IFIDPC=0, IFIDPCPLUS4=0, IFIDIns=0, IFIDValid=0
  - all counters=0
- rst overrides every other input.
- PC update, per edge, first matching rule wins:
  1. rst.
  2. PCWr=1 and IFIDRst=1: PC <= {NPC[31:2],2'b00}. The redirect is taken even when IMReady=0, because the fetch at the old PC is discarded.
  3. PCWr=1 and IMReady=1: PC <= {NPC[31:2],2'b00}.
  4. Otherwise PC holds.
- PC[1:0] is always 0.
- IF/ID update, per edge, first matching rule wins:
  1. rst.
  2. IFIDRst=1: IFIDIns=0, IFIDValid=0, IFIDPC=0, IFIDPCPLUS4=0. Flush dominates IFIDWr.
  3. IFIDWr=1, IMReady=0: bubble inserted; IFIDIns=0, IFIDValid=0, PC fields=0.
  4. IFIDWr=1, IMReady=1: IFIDIns<=IMInstr, IFIDPC<=PC, IFIDPCPLUS4<=PC+4 (mod 2^32), IFIDValid<=1.
  5. IFIDWr=0: all IF/ID fields hold.
- Latency:
  - Instruction fetched at PC in cycle n appears on IFIDIns after edge n.
  - NPC presented in cycle n appears on PC after edge n.
- Stall (PCWr=0, IFIDWr=0, IFIDRst=0): PC and IF/ID both frozen, regardless of IMReady.
- IM wait with PCWr=1, IFIDWr=1: PC holds, bubble enters IF/ID, and the same PC is re-fetched the next cycle.
- Counters:
  - StallCnt +1 each non-reset edge with PCWr=0.
  - FlushCnt +1 each non-reset edge with IFIDRst=1.
  - IMWaitCnt +1 each non-reset edge with PCWr=1, IFIDRst=0, IMReady=0.
  - PCWr=0 and IMReady=0 together count as a stall only.
  - All counters saturate at all-ones, with no wrap.
- Reset mid-stall or mid-wait: all state returns to reset values the same edge; no pending redirect survives.
- The block contains no combinational path from inputs to outputs; all outputs are registers.

Test Plan:
- Reset then free-run, IMReady=1, PCWr=IFIDWr=1, NPC=PC+4, IMInstr=PC-derived.
  - After 3 edges: PC=0x300C, IFIDPC=0x3008, IFIDPCPLUS4=0x300C, IFIDValid=1.
- Load-use stall: PCWr=0, IFIDWr=0 for 2 cycles at PC=0x3010.
  - PC stays 0x3010; IF/ID unchanged; StallCnt=2.
  - Resume: IF/ID gets the 0x3010 instruction.
- Jump redirect: IFIDRst=1, PCWr=1, IFIDWr=0, NPC=0x3100, IMReady=0.
  - Next edge: PC=0x3100, IFIDIns=0, IFIDValid=0, FlushCnt=1, IMWaitCnt unchanged.
- IM wait: IMReady=0 for 3 cycles at PC=0x3020.
  - PC holds 0x3020; three bubbles (IFIDValid=0); IMWaitCnt=3.
  - When IMReady=1: IFIDPC=0x3020, valid.
- Misaligned NPC=0x3007 with PCWr=1, IMReady=1 -> PC=0x3004.
- Counter saturation: force PCWr=0 for 65540 cycles -> StallCnt=0xFFFF; then rst=1 mid-stall -> all counters 0, PC=0x3000.
